// File: rtl/bcd_seg7_pkg.sv
// Shared constants for the BCD counter: digit width, segment codes and decoder.
package bcd_seg7_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    // Active-low segment patterns, bit order {A,B,C,D,E,F,G} with A as MSB.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_D0    = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_D1    = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_D2    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_D3    = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_D4    = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_D5    = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_D6    = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_D7    = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_D8    = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_D9    = 7'b0000100;

    // BCD digit to segment pattern; non-BCD codes show blank.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] d);
        case (d)
            4'd0:    seg_decode = SEG_D0;
            4'd1:    seg_decode = SEG_D1;
            4'd2:    seg_decode = SEG_D2;
            4'd3:    seg_decode = SEG_D3;
            4'd4:    seg_decode = SEG_D4;
            4'd5:    seg_decode = SEG_D5;
            4'd6:    seg_decode = SEG_D6;
            4'd7:    seg_decode = SEG_D7;
            4'd8:    seg_decode = SEG_D8;
            4'd9:    seg_decode = SEG_D9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown_counter_seg7_digit.sv
// One BCD digit of the ripple chain: holds 0..9, steps on inc/dec enables.
module bcd_digit
    import bcd_seg7_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc_en,
    input  logic               dec_en,
    output logic [DIGIT_W-1:0] value,
    output logic               carry_out,
    output logic               borrow_out
);

    assign carry_out  = inc_en & (value == DIGIT_W'(9));
    assign borrow_out = dec_en & (value == DIGIT_W'(0));

    // Digit register: 9 rolls to 0 on increment, 0 rolls to 9 on decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc_en) begin
            value <= carry_out ? DIGIT_W'(0) : value + DIGIT_W'(1);
        end else if (dec_en) begin
            value <= borrow_out ? DIGIT_W'(9) : value - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_updown_counter_seg7.sv
// N-digit BCD up/down counter with press edge detection and registered 7-segment drive.
module bcd_updown_counter_seg7
    import bcd_seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 2,
    parameter int unsigned WRAP_MODE     = 1,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Inc,
    input  logic                          i_Dec,
    input  logic                          i_Clear,
    output logic [DIGIT_W*NUM_DIGITS-1:0] o_Count_BCD,
    output logic [SEG_W*NUM_DIGITS-1:0]   o_Segments,
    output logic                          o_Limit
);

    localparam int unsigned SEGS_W = SEG_W * NUM_DIGITS;

    logic r_inc, r_dec, r_clr;
    logic inc_pulse, dec_pulse, clr_pulse;
    logic at_max, at_min;
    logic inc_req, dec_req;
    logic step_inc, step_dec;
    logic limit_c;
    logic [SEGS_W-1:0] seg_next;
    logic [SEGS_W-1:0] seg_rst;
    logic              higher_zero;
    logic [DIGIT_W-1:0] cur_digit;
    int unsigned       k;

    assign inc_pulse = i_Inc   & ~r_inc;
    assign dec_pulse = i_Dec   & ~r_dec;
    assign clr_pulse = i_Clear & ~r_clr;

    // Previous input levels for rising-edge detection.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_inc <= 1'b0;
            r_dec <= 1'b0;
            r_clr <= 1'b0;
        end else begin
            r_inc <= i_Inc;
            r_dec <= i_Dec;
            r_clr <= i_Clear;
        end
    end

    // Limit detection, request arbitration and saturate gating.
    always_comb begin
        at_max = 1'b1;
        at_min = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (o_Count_BCD[DIGIT_W*i +: DIGIT_W] != DIGIT_W'(9)) at_max = 1'b0;
            if (o_Count_BCD[DIGIT_W*i +: DIGIT_W] != DIGIT_W'(0)) at_min = 1'b0;
        end
        inc_req  = inc_pulse & ~dec_pulse & ~clr_pulse;
        dec_req  = dec_pulse & ~inc_pulse & ~clr_pulse;
        limit_c  = (inc_req & at_max) | (dec_req & at_min);
        step_inc = inc_req & ((WRAP_MODE != 0) | ~at_max);
        step_dec = dec_req & ((WRAP_MODE != 0) | ~at_min);
    end

    // Ripple chain: each digit steps when all lower digits carry or borrow.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
        logic inc_en, dec_en, carry, borrow;
        if (g == 0) begin : gen_lsd
            assign inc_en = step_inc;
            assign dec_en = step_dec;
        end else begin : gen_upper
            assign inc_en = gen_digit[g-1].carry;
            assign dec_en = gen_digit[g-1].borrow;
        end
        bcd_digit u_digit (
            .clk        (i_Clk),
            .rst_n      (i_Rst_L),
            .clr        (clr_pulse),
            .inc_en     (inc_en),
            .dec_en     (dec_en),
            .value      (o_Count_BCD[DIGIT_W*g +: DIGIT_W]),
            .carry_out  (carry),
            .borrow_out (borrow)
        );
    end

    // Limit pulse aligned with the count update.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) o_Limit <= 1'b0;
        else          o_Limit <= limit_c;
    end

    // Segment decode with leading-zero blanking, scanned from the top digit down.
    always_comb begin
        seg_next    = '0;
        seg_rst     = '0;
        higher_zero = 1'b1;
        cur_digit   = '0;
        k           = 0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            k           = NUM_DIGITS - 1 - i;
            cur_digit   = o_Count_BCD[DIGIT_W*k +: DIGIT_W];
            higher_zero = higher_zero & (cur_digit == DIGIT_W'(0));
            if ((BLANK_LEADING != 0) && (k != 0) && higher_zero)
                seg_next[SEG_W*k +: SEG_W] = SEG_BLANK;
            else
                seg_next[SEG_W*k +: SEG_W] = seg_decode(cur_digit);
            if ((BLANK_LEADING != 0) && (k != 0))
                seg_rst[SEG_W*k +: SEG_W] = SEG_BLANK;
            else
                seg_rst[SEG_W*k +: SEG_W] = SEG_D0;
        end
    end

    // Segment register, one cycle behind the count.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) o_Segments <= seg_rst;
        else          o_Segments <= seg_next;
    end

endmodule
